// File: rtl/key_scanner.sv
// Keypad front end for the calculator core: scans a 4x4 active-low matrix plus a CLEAR key,
// synchronises and debounces them, and emits one single-cycle {op, num} keystroke per press.
module key_scanner #(
  parameter int SCAN_HOLD = 4,
  parameter int DEBOUNCE  = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [3:0]  row_in,
  input  logic        clr_n,
  output logic [3:0]  col_out,
  output logic [11:0] key_out,
  output logic        key_held
);

  localparam int CNT_MAX = (SCAN_HOLD > DEBOUNCE) ? SCAN_HOLD : DEBOUNCE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(SCAN_HOLD - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);

  localparam logic [11:0] WORD_NONE  = 12'h000;
  localparam logic [11:0] WORD_CLEAR = 12'h800;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_EMIT     = 2'd2;
  localparam logic [1:0] ST_WAIT     = 2'd3;

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic          clr_s1;
  logic          clr_s2;

  logic [1:0]    state;
  logic [1:0]    col_idx;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] db_cnt;
  logic [3:0]    row_pat;
  logic [1:0]    row_idx;

  logic [CW-1:0] clr_cnt;
  logic          clr_armed;
  logic          clr_fire;

  logic [3:0]    row_low;
  logic          one_low;
  logic [1:0]    low_idx;
  logic [3:0]    key_idx;
  logic [11:0]   key_word;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      clr_s1 <= 1'b1;
      clr_s2 <= 1'b1;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      clr_s1 <= clr_n;
      clr_s2 <= clr_s1;
    end
  end

  // Exactly one low row is a clean single press; anything more is a ghost or chord.
  assign row_low = ~row_s2;
  assign one_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);

  always_comb begin
    low_idx = 2'd0;
    case (row_low)
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  assign key_idx  = {row_idx, col_idx};
  assign key_word = (key_idx < 4'd10) ? {4'h1, 4'h0, key_idx} : {key_idx - 4'd8, 8'h00};

  assign col_out = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ST_SCAN;
      col_idx  <= 2'd0;
      hold_cnt <= '0;
      db_cnt   <= '0;
      row_pat  <= 4'hF;
      row_idx  <= 2'd0;
      key_held <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (one_low) begin
              row_pat <= row_s2;
              row_idx <= low_idx;
              db_cnt  <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s2 == row_pat) begin
            if (db_cnt == DB_LAST) begin
              db_cnt <= '0;
              state  <= ST_EMIT;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt   <= '0;
            hold_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            state    <= ST_SCAN;
          end
        end
        ST_EMIT: begin
          key_held <= 1'b1;
          db_cnt   <= '0;
          state    <= ST_WAIT;
        end
        default: begin
          // Only the latched row matters on release; other keys in the column are ignored.
          if (row_s2[row_idx]) begin
            if (db_cnt == DB_LAST) begin
              db_cnt   <= '0;
              hold_cnt <= '0;
              key_held <= 1'b0;
              col_idx  <= col_idx + 2'd1;
              state    <= ST_SCAN;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign clr_fire = clr_armed && !clr_s2 && (clr_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      clr_cnt   <= '0;
      clr_armed <= 1'b1;
    end else if (clr_armed) begin
      if (clr_s2) begin
        clr_cnt <= '0;
      end else if (clr_cnt == DB_LAST) begin
        clr_cnt   <= '0;
        clr_armed <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end else begin
      if (!clr_s2) begin
        clr_cnt <= '0;
      end else if (clr_cnt == DB_LAST) begin
        clr_cnt   <= '0;
        clr_armed <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // CLEAR wins a same-cycle collision; the matrix key is consumed and never re-emitted.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      key_out <= WORD_NONE;
    end else if (clr_fire) begin
      key_out <= WORD_CLEAR;
    end else if (state == ST_EMIT) begin
      key_out <= key_word;
    end else begin
      key_out <= WORD_NONE;
    end
  end

endmodule

// File: doc/key_scanner.md
Name: key_scanner

Overview:
- Front-end keypad stage that directly feeds the calculator core's keyIn port.
- Scans a 4x4 active-low key matrix and a dedicated CLEAR key, synchronises and debounces them, and decodes them into the 12-bit keystroke word {op[11:8], num[7:0]}.
- Emits exactly one single-cycle keystroke per physical press; key_out = NONE (12'h000) in every other cycle.

Parameters:
- SCAN_HOLD, 4: cycles each column is driven before advancing; legal range >= 3.
- DEBOUNCE, 4: consecutive stable samples required to accept a press or a release; legal range >= 2.

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- row_in  in  4  raw matrix rows, active-low, asynchronous
- clr_n  in  1  raw CLEAR key, active-low, asynchronous
- col_out  out  4  column drive, one-cold (only the driven column is 0)
- key_out  out  12  keystroke word: [11:8] op, [7:0] num; registered
- key_held  out  1  high while an accepted matrix key has not yet been released

Behaviour:
- Op encoding: NONE=0, NUMBER=1, PLUS=2, MINUS=3, EQUALS=4, NEGATE=5, LP=6, RP=7, CLEAR=8.
- Key index k = 4*row + col. Mapping:
  - k = 0..9: NUMBER with num = k.
  - k = 10..15: PLUS, MINUS, EQUALS, NEGATE, LP, RP respectively, with num = 0.
  - CLEAR is emitted with num = 0.
- Reset values: col_out = 4'b1110 (column 0), key_out = 12'h000, key_held = 0, FSM in SCAN, all counters 0.
- Synchronisers: row_in and clr_n each pass through a 2-flop synchroniser; these reset to all-ones (not pressed).
- The row sample is taken only on the last cycle of each SCAN_HOLD period, so the 2-cycle synchroniser lag has settled.
- SCAN:
  - Column index advances every SCAN_HOLD cycles and wraps 3 -> 0.
  - At a sample point with exactly one row low: latch row and col, freeze the column, go to DEBOUNCE.
  - At a sample point with two or more rows low (ghost or multi-key): ignore and keep scanning.
- DEBOUNCE:
  - Each cycle, compare the synced rows with the latched pattern.
  - Match: increment the counter. Mismatch: clear the counter and return to SCAN, resuming at the next column.
  - When the counter reaches DEBOUNCE: go to EMIT.
- EMIT (1 cycle): key_out takes the decoded word on the next clock edge and holds it for exactly one cycle. key_held goes to 1. Next state is WAIT_RELEASE.
- WAIT_RELEASE:
  - Column stays frozen; key_out = NONE.
  - The latched row must read high for DEBOUNCE consecutive cycles; any low sample resets the count.
  - On completion: key_held goes to 0, the column advances, and the FSM returns to SCAN.
- Press-to-output latency: key_out becomes valid DEBOUNCE+1 cycles after the first matching post-sync sample.
- CLEAR path:
  - Independent debounce counter; clr_n must be low for DEBOUNCE consecutive cycles.
  - Emits one CLEAR word, then requires DEBOUNCE high cycles before it can re-arm.
- Simultaneous events: if a CLEAR emit and a matrix EMIT fall in the same cycle, CLEAR is output and the matrix key is dropped. The matrix FSM still proceeds to WAIT_RELEASE, so the dropped key is never emitted later.
- Holding a key never auto-repeats.
- Any asynchronous assertion of rst_b mid-press returns everything to reset values immediately. A key still held when reset deasserts is re-detected by normal scanning and emitted once.
- Counters are sized to hold at least max(SCAN_HOLD, DEBOUNCE); there is no overflow path because counters stop at the threshold.

Test Plan:
- Reset, no keys, 64 cycles:
  - col_out cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 cycles.
  - key_out stays 12'h000 and key_held = 0 throughout.
- Press k = 7 (row 1, col 3) stably for 40 cycles, then release:
  - key_out = 12'h107 for exactly one cycle; key_held = 1 until 4 clean high cycles after release; no second emit.
- Press k = 12 with bounce (low 2 cycles, high 1 cycle, then low steady):
  - The first attempt aborts; a single 12'h400 (EQUALS) is emitted once the row is stable.
- Rows 0 and 2 low in the same column:
  - No emit; scanning continues; key_out stays 12'h000.
- clr_n low for 10 cycles in the same cycle that k = 3 completes debounce:
  - key_out = 12'h800 for one cycle; 12'h103 is never emitted; key_held = 1 until k = 3 is released.
- Assert rst_b while in WAIT_RELEASE holding k = 10:
  - Outputs return to reset values immediately.
  - After deassert, with the key still held, exactly one 12'h200 (PLUS) is emitted.
